// File: rtl/bist_lfsr_misr.sv
// Built-in self-test wrapper: an LFSR drives pseudo-random patterns into a
// netlist under test and a MISR compacts its responses into a signature that
// is compared against a golden value once the run completes.
module bist_lfsr_misr #(
  parameter int                N_IN      = 14,
  parameter int                N_OUT     = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
  parameter int                CNT_W     = 16,
  parameter int                DUT_LAT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic [MISR_W-1:0] golden,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              validIn;
  logic              capture;
  logic              sigMatch;
  logic [LFSR_W-1:0] lfsrStep;
  logic [LFSR_W-1:0] seedFixed;
  logic [MISR_W-1:0] dutOutExt;

  // A fresh pattern is launched into the DUT on every RUN cycle.
  assign validIn   = (state_q == RUN);
  assign sigMatch  = (misr_q == golden);
  assign lfsrStep  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
  assign seedFixed = (seed == '0) ? LFSR_W'(1) : seed;

  // Zero-extend the DUT response into the low bits of the MISR word.
  always_comb begin
    dutOutExt = '0;
    dutOutExt[N_OUT-1:0] = dut_out;
  end

  // The capture strobe trails pattern launch by the DUT latency.
  generate
    if (DUT_LAT == 0) begin : g_comb_dut
      assign capture = validIn;
    end else begin : g_pipe_dut
      logic [DUT_LAT-1:0] validPipe_q;

      // Delay line of launch flags matching the DUT's register depth.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          validPipe_q <= '0;
        end else begin
          validPipe_q <= (validPipe_q << 1) | DUT_LAT'(validIn);
        end
      end

      assign capture = validPipe_q[DUT_LAT-1];
    end
  endgenerate

  // Next-state logic for sequencing, pattern generation and compaction.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pass_d  = pass_q;

    if (done_q) begin
      pass_d = sigMatch;
    end

    if (capture) begin
      misr_d = (misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0) ^ dutOutExt;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lfsr_d = seedFixed;
          misr_d = '0;
          cnt_d  = num_pat;
          pass_d = 1'b0;
          if (num_pat == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (DUT_LAT == 0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DUT_LAT);
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          lfsr_d = lfsrStep;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in    = lfsr_q[N_IN-1:0];
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;
  assign pass      = done_q ? sigMatch : pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_bist_lfsr_misr.sv
// Self-checking bench: a combinational-DUT instance and a two-stage
// registered-DUT instance run side by side against a loop-based model.
module tb_bist_lfsr_misr;

  localparam logic [15:0] POLY = 16'hB400;

  typedef struct {
    logic [15:0] seed;
    int          numPat;
    bit          tie;
    logic [7:0]  tieVal;
    bit          hasConst;
    logic [15:0] constSig;
    logic [15:0] gx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seedIn;
  logic [15:0] numPatIn;
  logic [15:0] goldenIn;
  logic        tie;
  logic [7:0]  tieVal;

  logic [13:0] dutIn0, dutIn2;
  logic [7:0]  dutOut0, dutOut2;
  logic        busy0, busy2, done0, done2, pass0, pass2;
  logic [15:0] sig0, sig2;
  logic [7:0]  stage1 = 8'h00;
  logic [7:0]  stage2 = 8'h00;

  int nAssert = 0;
  int nFail   = 0;

  int          doneAt0, doneAt2, busyCnt0, busyCnt2;
  logic [15:0] sigAt0, sigAt2;
  logic        passAt0, passAt2;
  logic [13:0] obsPats[$];
  logic [15:0] expPats[$];
  vec_t        vecs[$];

  // Free-running clock.
  always #5 clk = ~clk;

  // Arbitrary 14-in/8-out logic cone standing in for the reference netlist.
  function automatic logic [7:0] refNet(input logic [13:0] x);
    logic [7:0] a;
    a = x[7:0] + x[13:6];
    return a ^ {x[13:10], x[3:0]} ^ {x[4] & x[9], 7'b0};
  endfunction

  assign dutOut0 = tie ? tieVal : refNet(dutIn0);

  // Same logic cone behind two register stages for the latency instance.
  always @(posedge clk) begin
    stage1 <= tie ? tieVal : refNet(dutIn2);
    stage2 <= stage1;
  end
  assign dutOut2 = stage2;

  bist_lfsr_misr #(.DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seedIn), .num_pat(numPatIn),
    .golden(goldenIn), .dut_in(dutIn0), .dut_out(dutOut0), .busy(busy0),
    .done(done0), .pass(pass0), .signature(sig0)
  );

  bist_lfsr_misr #(.DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seedIn), .num_pat(numPatIn),
    .golden(goldenIn), .dut_in(dutIn2), .dut_out(dutOut2), .busy(busy2),
    .done(done2), .pass(pass2), .signature(sig2)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nAssert++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, actual, actual, expected, expected);
    end
  endtask

  // Reference: walk the pattern sequence and fold responses into a signature.
  task automatic modelRun(input logic [15:0] s, input int n, input bit tieIn,
                          input logic [7:0] tv, output logic [15:0] sigOut);
    int unsigned st;
    int unsigned acc;
    int unsigned resp;
    st  = (s == 16'h0) ? 1 : int'(s);
    acc = 0;
    expPats.delete();
    for (int i = 0; i < n; i++) begin
      expPats.push_back(16'(st));
      resp = tieIn ? int'(tv) : int'(refNet(14'(st)));
      acc  = (acc / 2) ^ (((acc % 2) == 1) ? int'(POLY) : 0) ^ resp;
      st   = (st / 2) ^ (((st % 2) == 1) ? int'(POLY) : 0);
    end
    sigOut = 16'(acc);
  endtask

  function automatic vec_t mkVec(input logic [15:0] s, input int n, input bit t,
                                 input logic [7:0] tv, input bit hc,
                                 input logic [15:0] cs, input logic [15:0] gx);
    vec_t v;
    v.seed = s; v.numPat = n; v.tie = t; v.tieVal = tv;
    v.hasConst = hc; v.constSig = cs; v.gx = gx;
    return v;
  endfunction

  // Launch one run and observe both instances cycle by cycle.
  task automatic applyStimulus(input logic [15:0] s, input int n, input logic [15:0] g,
                               input bit tieIn, input logic [7:0] tv,
                               input bit disturb, input int resetAt);
    int limit;
    limit    = n + 10;
    seedIn   = s;
    numPatIn = 16'(n);
    goldenIn = g;
    tie      = tieIn;
    tieVal   = tv;
    repeat (3) @(negedge clk);
    doneAt0 = -1; doneAt2 = -1; busyCnt0 = 0; busyCnt2 = 0;
    sigAt0 = 16'h0; sigAt2 = 16'h0; passAt0 = 1'b0; passAt2 = 1'b0;
    obsPats.delete();
    start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = disturb && (c == 4 || c == 9);
      if (c == resetAt) rst_n = 1'b0;
      if (busy0) begin
        busyCnt0++;
        obsPats.push_back(dutIn0);
      end
      if (busy2) busyCnt2++;
      if (done0 && doneAt0 < 0) begin
        doneAt0 = c; sigAt0 = sig0; passAt0 = pass0;
      end
      if (done2 && doneAt2 < 0) begin
        doneAt2 = c; sigAt2 = sig2; passAt2 = pass2;
      end
      if (doneAt0 >= 0 && doneAt2 >= 0) break;
    end
    start = 1'b0;
  endtask

  // Compare one completed run against the model and the timing rules.
  task automatic checkRun(input string tag, input int n, input logic [15:0] expSig, input bit expPass);
    checkOutput({tag, " done cycle lat0"}, doneAt0, n + 1);
    checkOutput({tag, " done cycle lat2"}, doneAt2, (n == 0) ? 1 : n + 3);
    checkOutput({tag, " busy cycles lat0"}, busyCnt0, n);
    checkOutput({tag, " busy cycles lat2"}, busyCnt2, (n == 0) ? 0 : n + 2);
    checkOutput({tag, " signature lat0"}, sigAt0, expSig);
    checkOutput({tag, " signature lat2"}, sigAt2, expSig);
    checkOutput({tag, " pass lat0"}, passAt0, expPass);
    checkOutput({tag, " pass lat2"}, passAt2, expPass);
    checkOutput({tag, " pattern count"}, obsPats.size(), n);
    for (int i = 0; i < n && i < obsPats.size(); i++) begin
      checkOutput({tag, $sformatf(" pattern %0d", i)}, obsPats[i], expPats[i][13:0]);
    end
    @(negedge clk);
    checkOutput({tag, " done single pulse lat0"}, done0, 0);
    checkOutput({tag, " done single pulse lat2"}, done2, 0);
    checkOutput({tag, " pass held lat0"}, pass0, expPass);
    checkOutput({tag, " pass held lat2"}, pass2, expPass);
    checkOutput({tag, " signature held lat0"}, sig0, expSig);
    checkOutput({tag, " signature held lat2"}, sig2, expSig);
  endtask

  initial begin
    logic [15:0] expSig;
    logic [13:0] lfsrRef[4];
    int          d0Cnt, d0First, d0Second, d2Cnt, d2First;
    bit          busyAfterRestart;

    rst_n = 1'b0; start = 1'b0; seedIn = 16'h0; numPatIn = 16'h0;
    goldenIn = 16'h0; tie = 1'b0; tieVal = 8'h0;

    // Reset then idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset busy", {busy0, busy2}, 0);
    checkOutput("reset done", {done0, done2}, 0);
    checkOutput("reset pass", {pass0, pass2}, 0);
    checkOutput("reset signature lat0", sig0, 0);
    checkOutput("reset signature lat2", sig2, 0);
    checkOutput("reset dut_in lat0", dutIn0, 0);
    checkOutput("reset dut_in lat2", dutIn2, 0);

    // Vector table: fixed corner cases followed by randomized runs.
    vecs.push_back(mkVec(16'h0001,   2, 1'b1, 8'h01, 1'b1, 16'hB401, 16'h0000));
    vecs.push_back(mkVec(16'h0001,   2, 1'b1, 8'h01, 1'b1, 16'hB401, 16'h0001));
    vecs.push_back(mkVec(16'h0000,   0, 1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000));
    vecs.push_back(mkVec(16'hABCD,   0, 1'b0, 8'h00, 1'b1, 16'h0000, 16'h0005));
    vecs.push_back(mkVec(16'h0000,   3, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000));
    vecs.push_back(mkVec(16'h0001,   1, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000));
    vecs.push_back(mkVec(16'h0001,   4, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000));
    vecs.push_back(mkVec(16'($urandom), 100, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mkVec(16'($urandom), int'($urandom_range(1, 40)), 1'b0, 8'h00, 1'b0, 16'h0000,
                           ($urandom_range(0, 1) == 1) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000));
    end

    foreach (vecs[i]) begin
      modelRun(vecs[i].seed, vecs[i].numPat, vecs[i].tie, vecs[i].tieVal, expSig);
      if (vecs[i].hasConst) expSig = vecs[i].constSig;
      applyStimulus(vecs[i].seed, vecs[i].numPat, expSig ^ vecs[i].gx,
                    vecs[i].tie, vecs[i].tieVal, 1'b0, 0);
      checkRun($sformatf("vec%0d", i), vecs[i].numPat, expSig, vecs[i].gx == 16'h0);
    end

    // Known LFSR pattern sequence from seed 1.
    lfsrRef[0] = 14'h0001; lfsrRef[1] = 14'h3400; lfsrRef[2] = 14'h1A00; lfsrRef[3] = 14'h2D00;
    modelRun(16'h0001, 4, 1'b0, 8'h00, expSig);
    applyStimulus(16'h0001, 4, expSig, 1'b0, 8'h00, 1'b0, 0);
    checkOutput("lfsr seq done cycle", doneAt0, 5);
    checkOutput("lfsr seq count", obsPats.size(), 4);
    for (int i = 0; i < 4 && i < obsPats.size(); i++) begin
      checkOutput($sformatf("lfsr seq pattern %0d", i), obsPats[i], lfsrRef[i]);
    end

    // Start pulses during RUN must not disturb the signature.
    modelRun(16'h5A5A, 30, 1'b0, 8'h00, expSig);
    applyStimulus(16'h5A5A, 30, expSig, 1'b0, 8'h00, 1'b1, 0);
    checkRun("start while busy", 30, expSig, 1'b1);

    // Reset at pattern 50 aborts the run, then a clean run reproduces it.
    modelRun(16'hC3A1, 100, 1'b0, 8'h00, expSig);
    applyStimulus(16'hC3A1, 100, expSig, 1'b0, 8'h00, 1'b0, 50);
    checkOutput("abort no done lat0", doneAt0, -1);
    checkOutput("abort no done lat2", doneAt2, -1);
    checkOutput("abort signature lat0", sig0, 0);
    checkOutput("abort signature lat2", sig2, 0);
    checkOutput("abort busy", {busy0, busy2}, 0);
    rst_n = 1'b1;
    applyStimulus(16'hC3A1, 100, expSig, 1'b0, 8'h00, 1'b0, 0);
    checkRun("rerun after abort", 100, expSig, 1'b1);

    // Start coincident with the done cycle restarts the combinational instance.
    modelRun(16'h1234, 5, 1'b0, 8'h00, expSig);
    seedIn = 16'h1234; numPatIn = 16'd5; goldenIn = expSig; tie = 1'b0;
    repeat (3) @(negedge clk);
    d0Cnt = 0; d0First = -1; d0Second = -1; d2Cnt = 0; d2First = -1; busyAfterRestart = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 6);
      if (c == 7) busyAfterRestart = busy0;
      if (done0) begin
        d0Cnt++;
        if (d0First < 0) d0First = c; else d0Second = c;
      end
      if (done2) begin
        d2Cnt++;
        if (d2First < 0) d2First = c;
      end
    end
    start = 1'b0;
    checkOutput("restart first done lat0", d0First, 6);
    checkOutput("restart second done lat0", d0Second, 12);
    checkOutput("restart done count lat0", d0Cnt, 2);
    checkOutput("restart busy after done lat0", busyAfterRestart, 1);
    checkOutput("restart ignored done lat2", d2First, 8);
    checkOutput("restart ignored count lat2", d2Cnt, 1);
    checkOutput("restart signature lat0", sig0, expSig);
    checkOutput("restart signature lat2", sig2, expSig);
    checkOutput("restart pass lat0", pass0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
